// File: rtl/serial_adder_pkg.sv
// Shared arithmetic definitions for the serial adder and subtractor family:
// controller state encodings and the counter-width helper.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the per-step datapath of the serial adder.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {Cout,S} = A + B + Cin, one bit per clock, LSB first,
// with a START handshake, BUSY while running and a one-cycle DONE pulse.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    import serial_adder_pkg::*;

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    logic w_sum_bit;
    logic w_carry_out;

    full_adder u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_sum_bit),
        .o_cout (w_carry_out)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_carry <= Cin;
                        r_cnt   <= '0;
                        r_s     <= '0;
                        r_cout  <= 1'b0;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the MSB so S is LSB-aligned after WIDTH steps.
                    r_s     <= {w_sum_bit, r_s[WIDTH-1:1]};
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_carry_out;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_cout  <= w_carry_out;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY = (r_state == ST_RUN);
    assign DONE = (r_state == ST_DONE);
    assign S    = r_s;
    assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus random
// operations compared against plain arithmetic A + B + Cin.
module tb_serial_adder;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] S;
    logic         Cout;

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .S     (S),
        .Cout  (Cout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    endfunction

    // One request: accepted on the edge after the first negedge; BUSY for W
    // cycles, DONE in the next, then IDLE with the result held.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input bit inject);
        logic [W:0] exp_res;
        exp_res = ref_add(a, b, cin);
        @(negedge CLK);
        A = a; B = b; Cin = cin; START = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge CLK);
            chk("busy_run", BUSY, 1);
            chk("done_early", DONE, 0);
            if (inject && i == 1) begin
                START = 1'b1; A = '1; B = '1; Cin = 1'b1;
            end else begin
                START = 1'b0;
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            end
        end
        @(negedge CLK);
        chk("done_pulse", DONE, 1);
        chk("busy_at_done", BUSY, 0);
        chk("sum", S, exp_res[W-1:0]);
        chk("cout", Cout, exp_res[W]);
        @(negedge CLK);
        chk("done_single", DONE, 0);
        chk("busy_idle", BUSY, 0);
        chk("sum_held", {Cout, S}, exp_res);
        $display("[TB] op A=%h B=%h Cin=%b inject=%0d -> S=%h Cout=%b (ref %h)",
                 a, b, cin, inject, S, Cout, exp_res);
    endtask

    initial begin
        logic [W:0] exp_bb [2];
        int         pulses [$];

        RST = 1'b1; START = 1'b0; A = '0; B = '0; Cin = 1'b0;

        // Reset and quiet period
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_s", S, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        repeat (10) begin
            @(negedge CLK);
            chk("idle_no_done", {BUSY, DONE}, 0);
        end

        // Directed results, including the all-ones wrap and mid-run START
        op(4'b0001, 4'b0011, 1'b0, 1'b0);
        op(4'b1101, 4'b0110, 1'b0, 1'b0);
        op(4'b1111, 4'b0000, 1'b1, 1'b0);
        op(4'b1010, 4'b0101, 1'b0, 1'b1);

        // START held: back-to-back, one result every W+1 cycles
        exp_bb[0] = ref_add(4'b0100, 4'b1100, 1'b0);
        exp_bb[1] = ref_add(4'b1000, 4'b1001, 1'b0);
        @(negedge CLK);
        A = 4'b0100; B = 4'b1100; Cin = 1'b0; START = 1'b1;
        for (int c = 1; c <= 2 * W + 4; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                A = 4'b1000; B = 4'b1001;
            end
            if (c == W + 2) START = 1'b0;
            if (DONE) begin
                if (pulses.size() < 2)
                    chk("b2b_result", {Cout, S}, exp_bb[pulses.size()]);
                pulses.push_back(c);
            end
        end
        chk("b2b_pulse_count", pulses.size(), 2);
        if (pulses.size() == 2) begin
            chk("b2b_first_latency", pulses[0], W + 1);
            chk("b2b_spacing", pulses[1] - pulses[0], W + 1);
        end
        $display("[TB] back-to-back pulses=%0d", pulses.size());

        // Reset mid-run aborts with no DONE
        @(negedge CLK);
        A = 4'b0111; B = 4'b0001; Cin = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_s", S, 0);
        chk("abort_cout", Cout, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        RST = 1'b0;
        repeat (W + 2) begin
            @(negedge CLK);
            chk("abort_no_done", DONE, 0);
        end
        $display("[TB] abort mid-run checked");
        op(4'b0010, 4'b0010, 1'b0, 1'b0);

        // Random operations with random mid-run START and idle gaps
        for (int n = 0; n < 40; n++) begin
            op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
